// File: rtl/sr_cmd_gen_if.sv
// Signal bundle between the raw request sources, the downstream SR flop and sr_cmd_gen.
// The master side drives the requests and flop feedback; the slave side is the command generator.
interface sr_cmd_gen_if;
    logic       set_raw;
    logic       clr_raw;
    logic       q_fb;
    logic       S;
    logic       R;
    logic       busy;
    logic       conflict;
    logic [7:0] conflict_cnt;

    modport master (
        output set_raw, clr_raw, q_fb,
        input  S, R, busy, conflict, conflict_cnt
    );

    modport slave (
        input  set_raw, clr_raw, q_fb,
        output S, R, busy, conflict, conflict_cnt
    );
endinterface

// File: rtl/sr_cmd_gen.sv
// Turns raw bouncy set/clear requests into mutually exclusive one-cycle S/R pulses,
// with a hold-off gap after every pulse and suppression of commands the flop already satisfies.
//
// state | meaning
// IDLE  | arbitrate pending requests against q_fb
// PULSE | S, R or conflict asserted for exactly one cycle
// HOLD  | forced idle gap, hold_cnt counting down to zero
module sr_cmd_gen #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned HOLDOFF    = 3
) (
    input logic        clk,
    input logic        rst_n,
    sr_cmd_gen_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_HOLD
    } state_t;

    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);

    // Bit 0 is the set channel, bit 1 the clear channel throughout.
    logic [1:0] set_meta;
    logic [1:0] clr_meta;
    logic [1:0] sync;
    logic [1:0] lvl;
    logic [1:0] lvl_d;
    logic [1:0] rise;
    logic [1:0] pend;
    logic [1:0] take;
    logic [7:0] deb_cnt [2];

    state_t     state;
    logic [7:0] hold_cnt;
    logic       s_q;
    logic       r_q;
    logic       conf_q;
    logic       busy_q;
    logic [7:0] conf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_meta <= '0;
            clr_meta <= '0;
        end else begin
            set_meta <= {set_meta[0], bus.set_raw};
            clr_meta <= {clr_meta[0], bus.clr_raw};
        end
    end

    assign sync = {clr_meta[1], set_meta[1]};

    // The level only moves after DEB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl   <= '0;
            lvl_d <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            lvl_d <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    lvl[i]     <= sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign rise = lvl & ~lvl_d;
    // Every pending bit is consumed by a decision in IDLE, whether or not it produces a pulse.
    assign take = (state == ST_IDLE) ? pend : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~take) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conf_q     <= 1'b0;
            busy_q     <= 1'b0;
            conf_cnt_q <= '0;
        end else begin
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            conf_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend == 2'b11) begin
                        state  <= ST_PULSE;
                        busy_q <= 1'b1;
                        conf_q <= 1'b1;
                        if (conf_cnt_q != 8'hFF) begin
                            conf_cnt_q <= conf_cnt_q + 8'd1;
                        end
                    end else if (pend[0] && !bus.q_fb) begin
                        state  <= ST_PULSE;
                        busy_q <= 1'b1;
                        s_q    <= 1'b1;
                    end else if (pend[1] && bus.q_fb) begin
                        state  <= ST_PULSE;
                        busy_q <= 1'b1;
                        r_q    <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (HOLD_INIT == 8'd0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_INIT;
                    end
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt - 8'd1;
                    if (hold_cnt <= 8'd1) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S            = s_q;
    assign bus.R            = r_q;
    assign bus.conflict     = conf_q;
    assign bus.busy         = busy_q;
    assign bus.conflict_cnt = conf_cnt_q;

endmodule
